trap_collector: RTL and testbench
=================================

// Module: trap_collector
// PURPOSE
//  Receiver/consumer of the rv_trap_t encoding. Collects exception reports from execute/LSU/decode
//  ports, keeps the single oldest one by robIdx_t age, and raises the trap when the ROB head reaches it.
//  Also takes pending interrupts at a commit boundary, then produces mcause/mepc/mtval and the mtvec redirect.
//  Sits between the ROB commit stage and the CSR file / fetch redirect path.
// PARAMETERS
//  NUM_EXC_PORT  3   number of exception report ports
//  XLEN          64  width of pc, tval and mtvec
// PORTS
//  clk               in   1                  clock
//  rst               in   1                  synchronous, active-high reset
//  i_exc_vld         in   NUM_EXC_PORT       exception report valid, one per port
//  i_exc_robIdx      in   NUM_EXC_PORT x robIdx_t  ROB index of the faulting instruction
//  i_exc_cause       in   NUM_EXC_PORT x 16  rv_trap_t::exception code
//  i_exc_pc          in   NUM_EXC_PORT x XLEN  pc of the faulting instruction
//  i_exc_tval        in   NUM_EXC_PORT x XLEN  fault address or instruction bits
//  i_squash_vld      in   1                  misprediction squash
//  i_squash_robIdx   in   robIdx_t           instructions strictly younger than this are squashed
//  i_commit_vld      in   1                  ROB head is valid this cycle
//  i_commit_robIdx   in   robIdx_t           ROB head index
//  i_commit_pc       in   XLEN               ROB head pc
//  i_intr_pend       in   16                 mip & mie, bit n = rv_trap_t::interrupt code n
//  i_intr_en         in   1                  global enable (mstatus.MIE or lower privilege)
//  i_mtvec           in   XLEN               [1:0] = mode (0 direct, 1 vectored), rest = BASE
//  o_commit_block    out  1                  stall ROB commit
//  o_trap_vld        out  1                  one-cycle pulse: write mcause/mepc/mtval, flush pipeline
//  o_trap_isIntr     out  1                  mcause interrupt bit
//  o_trap_cause      out  16                 mcause code
//  o_trap_epc        out  XLEN               value for mepc
//  o_trap_tval       out  XLEN               value for mtval
//  o_redirect_vld    out  1                  one-cycle pulse to fetch
//  o_redirect_pc     out  XLEN               trap vector target
// BEHAVIOUR
//  - Age rule: a is older than b iff (a.flipped==b.flipped) ? a.idx<b.idx : a.idx>b.idx.
//  - Held entry: {vld, robIdx, cause, pc, tval}. Each cycle, take the oldest valid incoming port.
//    If no entry is held, or the incoming report is strictly older, the held entry is replaced next cycle.
//    On equal robIdx, the existing entry is kept. Ports tie-break by lowest port number.
//  - Squash: if held robIdx is younger than i_squash_robIdx, clear vld. Same-cycle incoming reports
//    younger than the squash point are dropped. Squash is applied before the insert.
//  - FSM states are IDLE, TRAP and REDIR.
//  - IDLE->TRAP on i_commit_vld when either condition holds:
//      (a) the entry is held and its robIdx == i_commit_robIdx. This is an exception, and it has priority.
//      (b) i_intr_en and |i_intr_pend. This is an interrupt: epc = i_commit_pc, tval = 0.
//    Interrupt priority: mExter > mSoft > mTimer > sExter > sSoft > sTimer.
//  - TRAP (1 cycle):
//      o_trap_vld=1 with the registered cause/epc/tval; held entry cleared; o_commit_block=1.
//      Next state is REDIR.
//  - REDIR (1 cycle):
//      o_redirect_vld=1; o_commit_block=1.
//      o_redirect_pc = BASE for direct mode or for exceptions.
//      o_redirect_pc = BASE + 4*cause for vectored mode with an interrupt.
//      BASE = {i_mtvec[XLEN-1:2],2'b0}. Arithmetic is XLEN wide, wrap ignored.
//      Next state is IDLE.
//  - Exception reports arriving in TRAP/REDIR are dropped (the pipeline is being flushed).
//  - Squash in TRAP/REDIR is ignored.
//  - Latency: head match at cycle N -> o_trap_vld at N+1 -> o_redirect_vld at N+2.
//  - o_commit_block is also 1 in IDLE while the held entry matches the head, so the faulting
//    instruction never retires.
//  - Reset: state=IDLE, held vld=0. All outputs are 0 and the data outputs are zeroed.
//    Reset mid-TRAP/REDIR aborts with no further pulses.
// CONFIGURATION
//  TRAP_MTVAL_EN defined:
//    tval is stored per held entry and driven on o_trap_tval.
//  TRAP_MTVAL_EN undefined:
//    no tval storage; o_trap_tval is tied to 0; i_exc_tval is unused.
// TESTING
//  - Port1 reports robIdx{0,5} instLlegal(2) and port0 reports {0,3} loadFault(5) in the same cycle;
//    then head={0,3} -> o_trap_vld with cause=5, isIntr=0; 1 cycle later o_redirect_vld, pc=BASE.
//  - Held {0,2}, then squash at {0,1} -> entry cleared; head={0,2} produces no trap.
//  - Wrap: held {0,7}, incoming {1,0} -> held entry is kept.
//    Incoming {0,6} with held {1,0} -> replaced by {0,6}.
//  - mtvec=0x8000_0001, i_intr_pend bit7|bit11, i_intr_en=1, commit head valid:
//    cause=11, isIntr=1, epc=i_commit_pc, redirect=0x8000_002C.
//  - Head matches held exception while mTimer is pending -> exception is taken (cause=held code);
//    the interrupt is taken on a later commit.
//  - Assert rst during TRAP -> no o_redirect_vld, all outputs 0 next cycle.
//    With TRAP_MTVAL_EN off, o_trap_tval is always 0.

Source files
------------

// File: rtl/trap_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trap_collector                                               |
// | Description : Collects exception reports from execute/LSU/decode ports,    |
// |               keeps the single oldest report by ROB age and raises the     |
// |               trap when the ROB head reaches it. Also takes pending        |
// |               interrupts at a commit boundary and produces the             |
// |               mcause/mepc/mtval values plus the mtvec fetch redirect.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Configuration macro: TRAP_MTVAL_EN                                         |
// |   defined   : tval is stored with the held entry and driven on o_trap_tval |
// |   undefined : no tval storage, o_trap_tval tied to 0, i_exc_tval unused    |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst            clock, synchronous active-high reset                 |
// |   i_exc_*             per-port exception reports (vld/robIdx/cause/pc/tval)|
// |   i_squash_*          squash of everything strictly younger than robIdx    |
// |   i_commit_*          ROB head valid / index / pc                          |
// |   i_intr_pend/en      pending interrupts (mip & mie) and global enable     |
// |   i_mtvec             trap vector base and mode                            |
// |   o_commit_block      stall ROB commit                                     |
// |   o_trap_*            one-cycle trap pulse with mcause/mepc/mtval values   |
// |   o_redirect_*        one-cycle redirect pulse to fetch with target pc     |
// +----------------------------------------------------------------------------+
module trap_collector #(
   parameter int NUM_EXC_PORT = 3,
   parameter int XLEN         = 64,
   parameter int ROB_IDX_W    = 3      // index bits; robIdx adds one flip bit on top
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_EXC_PORT-1:0]              i_exc_vld,
   input  logic [NUM_EXC_PORT-1:0][ROB_IDX_W:0] i_exc_robIdx,
   input  logic [NUM_EXC_PORT-1:0][15:0]        i_exc_cause,
   input  logic [NUM_EXC_PORT-1:0][XLEN-1:0]    i_exc_pc,
   input  logic [NUM_EXC_PORT-1:0][XLEN-1:0]    i_exc_tval,
   input  logic                                 i_squash_vld,
   input  logic [ROB_IDX_W:0]                   i_squash_robIdx,
   input  logic                                 i_commit_vld,
   input  logic [ROB_IDX_W:0]                   i_commit_robIdx,
   input  logic [XLEN-1:0]                      i_commit_pc,
   input  logic [15:0]                          i_intr_pend,
   input  logic                                 i_intr_en,
   input  logic [XLEN-1:0]                      i_mtvec,
   output logic                                 o_commit_block,
   output logic                                 o_trap_vld,
   output logic                                 o_trap_isIntr,
   output logic [15:0]                          o_trap_cause,
   output logic [XLEN-1:0]                      o_trap_epc,
   output logic [XLEN-1:0]                      o_trap_tval,
   output logic                                 o_redirect_vld,
   output logic [XLEN-1:0]                      o_redirect_pc
);

   localparam int RW = ROB_IDX_W + 1;

   typedef logic [RW-1:0] rob_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRAP  = 2'd1,
      REDIR = 2'd2
   } state_t;

   // a is older than b: same lap compares indices directly, different laps invert.
   function automatic logic is_older(input rob_idx_t a, input rob_idx_t b);
      if (a[RW-1] == b[RW-1]) begin
         return a[RW-2:0] < b[RW-2:0];
      end else begin
         return a[RW-2:0] > b[RW-2:0];
      end
   endfunction

   // Standard machine/supervisor priority first; any other pending bit falls
   // back to the lowest-numbered one so a nonzero pend always yields a code.
   function automatic logic [15:0] intr_code(input logic [15:0] pend);
      logic [15:0] code;
      code = 16'd0;
      if      (pend[11]) code = 16'd11;
      else if (pend[3])  code = 16'd3;
      else if (pend[7])  code = 16'd7;
      else if (pend[9])  code = 16'd9;
      else if (pend[1])  code = 16'd1;
      else if (pend[5])  code = 16'd5;
      else begin
         for (int n = 15; n >= 0; n--) begin
            if (pend[n]) code = 16'(n);
         end
      end
      return code;
   endfunction

   state_t            state;
   state_t            next_state;

   logic              held_vld;
   rob_idx_t          held_rob;
   logic [15:0]       held_cause;
   logic [XLEN-1:0]   held_pc;

   logic              rec_intr;
   logic [15:0]       rec_cause;
   logic [XLEN-1:0]   rec_epc;

   logic              in_found;
   rob_idx_t          in_rob;
   logic [15:0]       in_cause;
   logic [XLEN-1:0]   in_pc;

`ifdef TRAP_MTVAL_EN
   logic [XLEN-1:0]   held_tval;
   logic [XLEN-1:0]   rec_tval;
   logic [XLEN-1:0]   in_tval;
`else
   logic              unused_tval;
   assign unused_tval = ^i_exc_tval;
`endif

   logic              held_live;
   logic              take_new;
   logic              head_match;
   logic              intr_ok;
   logic [XLEN-1:0]   vec_base;
   logic [XLEN-1:0]   redir_target;

   // Oldest surviving incoming report; strict comparison keeps the lowest port on ties.
   always_comb begin
      in_found = 1'b0;
      in_rob   = '0;
      in_cause = '0;
      in_pc    = '0;
`ifdef TRAP_MTVAL_EN
      in_tval  = '0;
`endif
      for (int p = 0; p < NUM_EXC_PORT; p++) begin
         if (i_exc_vld[p]
             && !(i_squash_vld && is_older(i_squash_robIdx, i_exc_robIdx[p]))
             && (!in_found || is_older(i_exc_robIdx[p], in_rob))) begin
            in_found = 1'b1;
            in_rob   = i_exc_robIdx[p];
            in_cause = i_exc_cause[p];
            in_pc    = i_exc_pc[p];
`ifdef TRAP_MTVAL_EN
            in_tval  = i_exc_tval[p];
`endif
         end
      end
   end

   // Squash is resolved before the insert decision.
   assign held_live  = held_vld && !(i_squash_vld && is_older(i_squash_robIdx, held_rob));
   assign take_new   = in_found && (!held_live || is_older(in_rob, held_rob));
   assign head_match = held_vld && (held_rob == i_commit_robIdx);
   assign intr_ok    = i_intr_en && (|i_intr_pend);

   assign vec_base     = {i_mtvec[XLEN-1:2], 2'b00};
   assign redir_target = (i_mtvec[1:0] == 2'b01 && rec_intr)
                         ? vec_base + (XLEN'(rec_cause) << 2)
                         : vec_base;

   // Held oldest exception
   always_ff @(posedge clk) begin
      if (rst) begin
         held_vld   <= 1'b0;
         held_rob   <= '0;
         held_cause <= '0;
         held_pc    <= '0;
`ifdef TRAP_MTVAL_EN
         held_tval  <= '0;
`endif
      end else if (state == IDLE) begin
         if (take_new) begin
            held_vld   <= 1'b1;
            held_rob   <= in_rob;
            held_cause <= in_cause;
            held_pc    <= in_pc;
`ifdef TRAP_MTVAL_EN
            held_tval  <= in_tval;
`endif
         end else begin
            held_vld <= held_live;
         end
      end else begin
         // Pipeline is being flushed: drop the entry and ignore reports/squash.
         held_vld <= 1'b0;
      end
   end

   // Trap record captured on the IDLE->TRAP transition; exception wins over interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         rec_intr  <= 1'b0;
         rec_cause <= '0;
         rec_epc   <= '0;
`ifdef TRAP_MTVAL_EN
         rec_tval  <= '0;
`endif
      end else if (state == IDLE && i_commit_vld) begin
         if (head_match) begin
            rec_intr  <= 1'b0;
            rec_cause <= held_cause;
            rec_epc   <= held_pc;
`ifdef TRAP_MTVAL_EN
            rec_tval  <= held_tval;
`endif
         end else if (intr_ok) begin
            rec_intr  <= 1'b1;
            rec_cause <= intr_code(i_intr_pend);
            rec_epc   <= i_commit_pc;
`ifdef TRAP_MTVAL_EN
            rec_tval  <= '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state     = state;
      o_commit_block = 1'b0;
      o_trap_vld     = 1'b0;
      o_trap_isIntr  = 1'b0;
      o_trap_cause   = '0;
      o_trap_epc     = '0;
      o_trap_tval    = '0;
      o_redirect_vld = 1'b0;
      o_redirect_pc  = '0;
      case (state)
         IDLE: begin
            o_commit_block = head_match;
            if (i_commit_vld && (head_match || intr_ok)) begin
               next_state = TRAP;
            end
         end
         TRAP: begin
            o_commit_block = 1'b1;
            o_trap_vld     = 1'b1;
            o_trap_isIntr  = rec_intr;
            o_trap_cause   = rec_cause;
            o_trap_epc     = rec_epc;
`ifdef TRAP_MTVAL_EN
            o_trap_tval    = rec_tval;
`endif
            next_state     = REDIR;
         end
         REDIR: begin
            o_commit_block = 1'b1;
            o_redirect_vld = 1'b1;
            o_redirect_pc  = redir_target;
            next_state     = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_trap_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trap_collector                                            |
// | Description : Self-checking bench for trap_collector: directed scenarios   |
// |               followed by random traffic checked every cycle against a     |
// |               behavioural model based on ROB-age arithmetic and a trap     |
// |               timeline.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_trap_collector;

   localparam int NP = 3;
   localparam int XL = 64;

   logic                   clk;
   logic                   rst;
   logic [NP-1:0]          exc_vld;
   logic [NP-1:0][3:0]     exc_rob;
   logic [NP-1:0][15:0]    exc_cause;
   logic [NP-1:0][XL-1:0]  exc_pc;
   logic [NP-1:0][XL-1:0]  exc_tval;
   logic                   squash_vld;
   logic [3:0]             squash_rob;
   logic                   commit_vld;
   logic [3:0]             commit_rob;
   logic [XL-1:0]          commit_pc;
   logic [15:0]            intr_pend;
   logic                   intr_en;
   logic [XL-1:0]          mtvec;
   logic                   commit_block;
   logic                   trap_vld;
   logic                   trap_isIntr;
   logic [15:0]            trap_cause;
   logic [XL-1:0]          trap_epc;
   logic [XL-1:0]          trap_tval;
   logic                   redirect_vld;
   logic [XL-1:0]          redirect_pc;

   trap_collector #(.NUM_EXC_PORT(NP), .XLEN(XL), .ROB_IDX_W(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_exc_vld       (exc_vld),
      .i_exc_robIdx    (exc_rob),
      .i_exc_cause     (exc_cause),
      .i_exc_pc        (exc_pc),
      .i_exc_tval      (exc_tval),
      .i_squash_vld    (squash_vld),
      .i_squash_robIdx (squash_rob),
      .i_commit_vld    (commit_vld),
      .i_commit_robIdx (commit_rob),
      .i_commit_pc     (commit_pc),
      .i_intr_pend     (intr_pend),
      .i_intr_en       (intr_en),
      .i_mtvec         (mtvec),
      .o_commit_block  (commit_block),
      .o_trap_vld      (trap_vld),
      .o_trap_isIntr   (trap_isIntr),
      .o_trap_cause    (trap_cause),
      .o_trap_epc      (trap_epc),
      .o_trap_tval     (trap_tval),
      .o_redirect_vld  (redirect_vld),
      .o_redirect_pc   (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   int            cyc   = 0;
   int            t_cyc = -100;   // cycle in which the trap pulse is due
   bit            h_vld = 1'b0;
   logic [3:0]    h_rob;
   logic [15:0]   h_cause;
   logic [XL-1:0] h_pc;
   logic [XL-1:0] h_tval;
   bit            rec_intr;
   logic [15:0]   rec_cause;
   logic [XL-1:0] rec_epc;
   logic [XL-1:0] rec_tval;

   task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // a older than b within a 16-entry circular space of 8 live slots
   function automatic bit older(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] d;
      d = b - a;
      return (d >= 4'd1) && (d <= 4'd7);
   endfunction

   function automatic logic [15:0] pick_intr(input logic [15:0] pend);
      int prio [6] = '{11, 3, 7, 9, 1, 5};
      for (int k = 0; k < 6; k++) begin
         if (pend[prio[k]]) return 16'(prio[k]);
      end
      for (int k = 0; k < 16; k++) begin
         if (pend[k]) return 16'(k);
      end
      return 16'd0;
   endfunction

   task automatic clr();
      exc_vld    = '0;
      exc_rob    = '0;
      exc_cause  = '0;
      exc_pc     = '0;
      exc_tval   = '0;
      squash_vld = 1'b0;
      squash_rob = '0;
      commit_vld = 1'b0;
      commit_rob = '0;
      commit_pc  = '0;
      intr_pend  = '0;
      intr_en    = 1'b0;
   endtask

   // Check outputs mid-cycle against the model, advance the model, move to next cycle.
   task automatic step();
      bit            in_trap, in_redir, found;
      logic [XL-1:0] base, e_rpc;
      logic [3:0]    b_rob;
      int            bp;
      #4;
      in_trap  = (cyc == t_cyc);
      in_redir = (cyc == t_cyc + 1);
      base  = {mtvec[XL-1:2], 2'b00};
      e_rpc = (mtvec[1:0] == 2'd1 && rec_intr) ? base + 64'(rec_cause) * 64'd4 : base;
      chk("trap_vld",     XL'(trap_vld),     XL'(in_trap));
      chk("trap_isIntr",  XL'(trap_isIntr),  in_trap ? XL'(rec_intr) : '0);
      chk("trap_cause",   XL'(trap_cause),   in_trap ? XL'(rec_cause) : '0);
      chk("trap_epc",     trap_epc,          in_trap ? rec_epc : '0);
      chk("trap_tval",    trap_tval,         in_trap ? rec_tval : '0);
      chk("redirect_vld", XL'(redirect_vld), XL'(in_redir));
      chk("redirect_pc",  redirect_pc,       in_redir ? e_rpc : '0);
      chk("commit_block", XL'(commit_block),
          XL'(in_trap || in_redir || (h_vld && h_rob == commit_rob)));
      if (rst) begin
         h_vld = 1'b0;
         t_cyc = -100;
      end else if (in_trap) begin
         h_vld = 1'b0;
      end else if (!in_redir) begin
         if (commit_vld && h_vld && h_rob == commit_rob) begin
            rec_intr = 1'b0; rec_cause = h_cause; rec_epc = h_pc; rec_tval = h_tval;
            t_cyc = cyc + 1;
         end else if (commit_vld && intr_en && (|intr_pend)) begin
            rec_intr = 1'b1; rec_cause = pick_intr(intr_pend); rec_epc = commit_pc; rec_tval = '0;
            t_cyc = cyc + 1;
         end
         if (squash_vld && h_vld && older(squash_rob, h_rob)) h_vld = 1'b0;
         found = 1'b0; bp = 0; b_rob = '0;
         for (int p = 0; p < NP; p++) begin
            if (exc_vld[p] && !(squash_vld && older(squash_rob, exc_rob[p]))
                && (!found || older(exc_rob[p], b_rob))) begin
               found = 1'b1; bp = p; b_rob = exc_rob[p];
            end
         end
         if (found && (!h_vld || older(b_rob, h_rob))) begin
            h_vld = 1'b1; h_rob = b_rob; h_cause = exc_cause[bp]; h_pc = exc_pc[bp];
`ifdef TRAP_MTVAL_EN
            h_tval = exc_tval[bp];
`else
            h_tval = '0;
`endif
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      mtvec = 64'h0000_0000_8000_0000;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      // Reset state
      step();
      rst = 1'b0;
      step();

      // Same-cycle reports: port0 {0,3} loadFault beats port1 {0,5} illegal
      exc_vld = 3'b011;
      exc_rob[0] = 4'd3; exc_cause[0] = 16'd5; exc_pc[0] = 64'h1000; exc_tval[0] = 64'hdead;
      exc_rob[1] = 4'd5; exc_cause[1] = 16'd2; exc_pc[1] = 64'h2000; exc_tval[1] = 64'hbeef;
      step();
      clr();
      commit_vld = 1'b1; commit_rob = 4'd3; commit_pc = 64'h1000;
      step();
      clr();
      chk("s1_trap_vld", XL'(trap_vld), 64'd1);
      chk("s1_cause", XL'(trap_cause), 64'd5);
      chk("s1_isIntr", XL'(trap_isIntr), 64'd0);
      step();
      chk("s1_redir_vld", XL'(redirect_vld), 64'd1);
      chk("s1_redir_pc", redirect_pc, 64'h8000_0000);
      step();

      // Squash clears held {0,2}; head {0,2} then produces no trap
      exc_vld = 3'b001; exc_rob[0] = 4'd2; exc_cause[0] = 16'd4; exc_pc[0] = 64'h3000;
      step();
      clr();
      squash_vld = 1'b1; squash_rob = 4'd1;
      step();
      clr();
      commit_vld = 1'b1; commit_rob = 4'd2;
      step();
      clr();
      chk("s2_no_trap", XL'(trap_vld), 64'd0);
      step();

      // Wrap: held {0,7} kept against incoming {1,0}
      exc_vld = 3'b001; exc_rob[0] = 4'd7; exc_cause[0] = 16'd6; exc_pc[0] = 64'h4000;
      step();
      exc_rob[0] = 4'd8; exc_cause[0] = 16'd1; exc_pc[0] = 64'h5000;
      step();
      clr();
      commit_vld = 1'b1; commit_rob = 4'd7;
      step();
      clr();
      chk("s3_keep_cause", XL'(trap_cause), 64'd6);
      step();
      step();
      // Held {1,0} replaced by incoming {0,6}
      exc_vld = 3'b001; exc_rob[0] = 4'd8; exc_cause[0] = 16'd1; exc_pc[0] = 64'h5000;
      step();
      exc_rob[0] = 4'd6; exc_cause[0] = 16'd13; exc_pc[0] = 64'h6000;
      step();
      clr();
      commit_vld = 1'b1; commit_rob = 4'd6;
      step();
      clr();
      chk("s3_replace_cause", XL'(trap_cause), 64'd13);
      chk("s3_replace_epc", trap_epc, 64'h6000);
      step();
      step();

      // Vectored interrupt: mExter beats mTimer
      mtvec = 64'h8000_0001;
      commit_vld = 1'b1; commit_rob = 4'd9; commit_pc = 64'h1234;
      intr_pend = 16'h0880; intr_en = 1'b1;
      step();
      clr();
      chk("s4_cause", XL'(trap_cause), 64'd11);
      chk("s4_isIntr", XL'(trap_isIntr), 64'd1);
      chk("s4_epc", trap_epc, 64'h1234);
      step();
      chk("s4_redir_pc", redirect_pc, 64'h8000_002C);
      step();

      // Exception at head wins over pending mTimer; interrupt taken later
      exc_vld = 3'b100; exc_rob[2] = 4'd4; exc_cause[2] = 16'd13; exc_pc[2] = 64'h7000;
      step();
      clr();
      commit_vld = 1'b1; commit_rob = 4'd4; commit_pc = 64'h7000;
      intr_pend = 16'h0080; intr_en = 1'b1;
      step();
      commit_vld = 1'b0;
      chk("s5_exc_cause", XL'(trap_cause), 64'd13);
      chk("s5_exc_isIntr", XL'(trap_isIntr), 64'd0);
      step();
      step();
      commit_vld = 1'b1; commit_rob = 4'd5; commit_pc = 64'h7004;
      step();
      clr();
      chk("s5_intr_cause", XL'(trap_cause), 64'd7);
      chk("s5_intr_isIntr", XL'(trap_isIntr), 64'd1);
      step();
      step();

      // Reset during TRAP aborts the redirect
      commit_vld = 1'b1; commit_rob = 4'd1; commit_pc = 64'h9000;
      intr_pend = 16'h0008; intr_en = 1'b1;
      step();
      clr();
      chk("s6_trap_vld", XL'(trap_vld), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s6_no_redir", XL'(redirect_vld), 64'd0);
      chk("s6_redir_pc", redirect_pc, 64'd0);
      chk("s6_trap_vld0", XL'(trap_vld), 64'd0);
      chk("s6_block0", XL'(commit_block), 64'd0);
      step();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         clr();
         for (int p = 0; p < NP; p++) begin
            exc_vld[p]   = ($urandom_range(0, 3) == 0);
            exc_rob[p]   = 4'($urandom);
            exc_cause[p] = 16'($urandom_range(0, 15));
            exc_pc[p]    = {$urandom, $urandom};
            exc_tval[p]  = {$urandom, $urandom};
         end
         squash_vld = ($urandom_range(0, 7) == 0);
         squash_rob = 4'($urandom);
         commit_vld = $urandom_range(0, 1) == 1;
         commit_rob = (h_vld && $urandom_range(0, 1) == 1) ? h_rob : 4'($urandom);
         commit_pc  = {$urandom, $urandom};
         intr_pend  = ($urandom_range(0, 7) == 0) ? (16'($urandom) & 16'h0AAA) : 16'h0;
         intr_en    = $urandom_range(0, 1) == 1;
         mtvec      = {$urandom, $urandom[31:2], 2'($urandom_range(0, 1))};
         rst        = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      clr();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
